// File: rtl/qspi_ram_responder.sv
// rtl/qspi_ram_responder.sv - device-side QSPI PSRAM model backing the framebuffer
//
// Purpose: decodes the host's PSRAM command set (0x66 RSTEN, 0x99 RST, 0x35 QPI
// enter, 0xF5 QPI exit, 0x38 quad write, 0xEB quad read). Everything runs on the
// host clock, and SIO is sampled on each rising edge while chip_enable is low.
//
// Ports:
//   clk          system clock, also used as the QSPI serial clock
//   rst          synchronous active-high reset
//   chip_enable  active-low select from the host
//   data_in      host-driven SIO[3:0]; bit 0 is the serial line in SPI mode
//   data_out     responder-driven SIO value (registered)
//   data_oe      output enable, 4'b0000 or 4'b1111 (registered)
//   qpi_mode     1 = commands arrive a nibble per cycle (registered)
//   busy         1 while selected and not idle (registered)

module qspi_ram_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 6,
  parameter     INIT_FILE   = "fb_init.hex"
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       chip_enable,
  input  logic [3:0] data_in,
  output logic [3:0] data_out,
  output logic [3:0] data_oe,
  output logic       qpi_mode,
  output logic       busy
);

  // The phase counter is 8 bits wide, so WAIT_CYCLES must stay below 256.
  localparam int CNT_W = 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    WDATA,
    DUMMY,
    RDATA,
    IGNORE
  } state_t;

  state_t                  state_q;
  logic [6:0]              cmd_q;       // command bits received so far
  logic [CNT_W-1:0]        cnt_q;       // cycles spent in the current phase
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    is_read_q;
  logic                    nib_q;       // 1 = the next nibble is the low nibble
  logic [3:0]              wnib_q;      // held high nibble of the write byte
  logic                    rst_armed_q;
  logic                    pend_q;      // a mode change is waiting for deselect
  logic                    pend_qpi_q;
  logic [3:0]              data_out_q;
  logic [3:0]              data_oe_q;
  logic                    qpi_q;
  logic                    busy_q;

  logic [7:0] mem [0:DEPTH-1];

  logic [7:0]            cmd_d;
  logic                  cmd_last_d;
  logic [ADDR_WIDTH-1:0] addr_shift_d;
  logic [7:0]            mem_byte_d;
  logic                  mem_we_d;

  always_comb begin
    cmd_d        = qpi_q ? {cmd_q[3:0], data_in} : {cmd_q, data_in[0]};
    cmd_last_d   = qpi_q ? (cnt_q == CNT_W'(1)) : (cnt_q == CNT_W'(7));
    // The 24-bit address is shifted through a narrow register, so only the
    // low ADDR_WIDTH bits survive.
    addr_shift_d = ADDR_WIDTH'({addr_q, data_in});
    mem_byte_d   = mem[addr_q];
    mem_we_d     = (state_q == WDATA) && !chip_enable && nib_q && !rst;
  end

  // The byte is committed on the edge that samples its low nibble.
  always_ff @(posedge clk) begin
    if (mem_we_d) begin
      mem[addr_q] <= {wnib_q, data_in};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      cnt_q       <= '0;
      addr_q      <= '0;
      is_read_q   <= 1'b0;
      nib_q       <= 1'b0;
      wnib_q      <= '0;
      rst_armed_q <= 1'b0;
      pend_q      <= 1'b0;
      pend_qpi_q  <= 1'b0;
      data_out_q  <= '0;
      data_oe_q   <= '0;
      qpi_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else if (chip_enable) begin
      // Deselect abandons any transfer; a pending mode change lands here.
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      data_oe_q  <= '0;
      data_out_q <= '0;
      nib_q      <= 1'b0;
      pend_q     <= 1'b0;
      if (pend_q) begin
        qpi_q <= pend_qpi_q;
      end
    end else begin
      busy_q <= 1'b1;
      cnt_q  <= cnt_q + CNT_W'(1);
      case (state_q)
        IDLE: begin
          cmd_q   <= cmd_d[6:0];
          cnt_q   <= CNT_W'(1);
          state_q <= CMD;
        end
        CMD: begin
          cmd_q <= cmd_d[6:0];
          if (cmd_last_d) begin
            cnt_q       <= '0;
            state_q     <= IGNORE;
            rst_armed_q <= (cmd_d == 8'h66);
            case (cmd_d)
              8'h38: begin
                state_q   <= ADDR;
                is_read_q <= 1'b0;
              end
              8'hEB: begin
                state_q   <= ADDR;
                is_read_q <= 1'b1;
              end
              8'h35: begin
                if (!qpi_q) begin
                  pend_q     <= 1'b1;
                  pend_qpi_q <= 1'b1;
                end
              end
              8'hF5: begin
                if (qpi_q) begin
                  pend_q     <= 1'b1;
                  pend_qpi_q <= 1'b0;
                end
              end
              8'h99: begin
                if (rst_armed_q) begin
                  pend_q     <= 1'b1;
                  pend_qpi_q <= 1'b0;
                end
              end
              default: ;
            endcase
          end
        end
        ADDR: begin
          addr_q <= addr_shift_d;
          if (cnt_q == CNT_W'(5)) begin
            cnt_q <= '0;
            nib_q <= 1'b0;
            if (!is_read_q) begin
              state_q <= WDATA;
            end else if (WAIT_CYCLES == 0) begin
              data_out_q <= mem[addr_shift_d][7:4];
              data_oe_q  <= 4'hF;
              nib_q      <= 1'b1;
              state_q    <= RDATA;
            end else begin
              state_q <= DUMMY;
            end
          end
        end
        DUMMY: begin
          // Load the first nibble on the last dummy edge so it is on the
          // bus during the first data cycle.
          if (cnt_q == CNT_W'(WAIT_CYCLES - 1)) begin
            data_out_q <= mem_byte_d[7:4];
            data_oe_q  <= 4'hF;
            nib_q      <= 1'b1;
            state_q    <= RDATA;
          end
        end
        RDATA: begin
          if (nib_q) begin
            data_out_q <= mem_byte_d[3:0];
            addr_q     <= addr_q + ADDR_WIDTH'(1);
            nib_q      <= 1'b0;
          end else begin
            data_out_q <= mem_byte_d[7:4];
            nib_q      <= 1'b1;
          end
        end
        WDATA: begin
          if (nib_q) begin
            addr_q <= addr_q + ADDR_WIDTH'(1);
            nib_q  <= 1'b0;
          end else begin
            wnib_q <= data_in;
            nib_q  <= 1'b1;
          end
        end
        IGNORE: ;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_out = data_out_q;
  assign data_oe  = data_oe_q;
  assign qpi_mode = qpi_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_qspi_ram_responder.sv
// tb/tb_qspi_ram_responder.sv - self-checking bench for qspi_ram_responder

module tb_qspi_ram_responder;

  localparam int W     = 6;
  localparam int DEPTH = 1024;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       chip_enable = 1'b1;
  logic [3:0] data_in = 4'h0;
  logic [3:0] data_out;
  logic [3:0] data_oe;
  logic       qpi_mode;
  logic       busy;

  qspi_ram_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(W)) dut (
    .clk(clk),
    .rst(rst),
    .chip_enable(chip_enable),
    .data_in(data_in),
    .data_out(data_out),
    .data_oe(data_oe),
    .qpi_mode(qpi_mode),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: byte array plus the mode/arming rules.
  logic [7:0] mem_m [DEPTH];
  bit         valid_m [DEPTH];
  bit         qpi_m = 1'b0;
  bit         armed_m = 1'b0;
  bit         pend_m = 1'b0;
  bit         pend_val_m = 1'b0;
  int unsigned written_q[$];

  logic [7:0] wdat [8];
  logic [7:0] rb [8];

  typedef struct {
    logic [7:0] cmd;
    logic       exp_qpi;
  } cmd_vec_t;
  cmd_vec_t tbl [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic ce, input logic [3:0] d);
    chip_enable = ce;
    data_in     = d;
    @(posedge clk);
    #1;
  endtask

  task automatic model_cmd(input logic [7:0] c);
    pend_m = 1'b0;
    case (c)
      8'h35: if (!qpi_m) begin pend_m = 1'b1; pend_val_m = 1'b1; end
      8'hF5: if (qpi_m) begin pend_m = 1'b1; pend_val_m = 1'b0; end
      8'h99: if (armed_m) begin pend_m = 1'b1; pend_val_m = 1'b0; end
      default: ;
    endcase
    armed_m = (c == 8'h66);
  endtask

  task automatic model_deselect();
    if (pend_m) qpi_m = pend_val_m;
    pend_m = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] c);
    if (qpi_m) begin
      step(1'b0, c[7:4]);
      step(1'b0, c[3:0]);
    end else begin
      for (int i = 7; i >= 0; i--) step(1'b0, {3'($urandom), c[i]});
    end
  endtask

  task automatic send_addr(input logic [23:0] a);
    for (int i = 5; i >= 0; i--) step(1'b0, a[i*4 +: 4]);
  endtask

  // Writes n bytes from wdat; with half set, sends one extra high nibble
  // before deselecting, which must not reach memory.
  task automatic do_write(input logic [23:0] a, input int n, input bit half);
    logic [9:0] ma;
    send_cmd(8'h38);
    model_cmd(8'h38);
    send_addr(a);
    for (int b = 0; b < n; b++) begin
      step(1'b0, wdat[b][7:4]);
      step(1'b0, wdat[b][3:0]);
      ma = a[9:0] + 10'(b);
      mem_m[ma] = wdat[b];
      valid_m[ma] = 1'b1;
      written_q.push_back(32'(ma));
    end
    if (half) step(1'b0, 4'($urandom));
    step(1'b1, 4'h0);
    model_deselect();
    check("wr_busy_after", busy, 0);
  endtask

  task automatic do_read(input logic [23:0] a, input int n);
    logic [3:0] hi;
    logic [9:0] ma;
    send_cmd(8'hEB);
    model_cmd(8'hEB);
    send_addr(a);
    for (int i = 0; i < W; i++) begin
      check("dummy_oe", data_oe, 4'h0);
      step(1'b0, 4'h0);
    end
    for (int b = 0; b < n; b++) begin
      check("rd_oe_hi", data_oe, 4'hF);
      hi = data_out;
      step(1'b0, 4'h0);
      check("rd_oe_lo", data_oe, 4'hF);
      rb[b] = {hi, data_out};
      step(1'b0, 4'h0);
      ma = a[9:0] + 10'(b);
      if (valid_m[ma]) check("rd_byte_model", rb[b], mem_m[ma]);
    end
    step(1'b1, 4'h0);
    model_deselect();
    check("rd_oe_after", data_oe, 4'h0);
    check("rd_busy_after", busy, 0);
  endtask

  task automatic mode_cmd(input logic [7:0] c);
    send_cmd(c);
    model_cmd(c);
    step(1'b1, 4'h0);
    model_deselect();
    check("mode_qpi", qpi_mode, qpi_m);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic exp_prev;
    int   r;
    int   n;
    logic [23:0] a;

    tbl[0]  = '{8'h66, 1'b0};
    tbl[1]  = '{8'h99, 1'b0};
    tbl[2]  = '{8'h35, 1'b1};
    tbl[3]  = '{8'h99, 1'b1};
    tbl[4]  = '{8'h66, 1'b1};
    tbl[5]  = '{8'h99, 1'b0};
    tbl[6]  = '{8'h35, 1'b1};
    tbl[7]  = '{8'hF5, 1'b0};
    tbl[8]  = '{8'hF5, 1'b0};
    tbl[9]  = '{8'h35, 1'b1};
    tbl[10] = '{8'h35, 1'b1};
    tbl[11] = '{8'h66, 1'b1};
    tbl[12] = '{8'hAB, 1'b1};
    tbl[13] = '{8'h99, 1'b1};

    rst = 1'b1;
    step(1'b1, 4'h0);
    step(1'b0, 4'h5);
    rst = 1'b0;
    check("reset_data_out", data_out, 4'h0);
    check("reset_oe", data_oe, 4'h0);
    check("reset_qpi", qpi_mode, 0);
    check("reset_busy", busy, 0);
    step(1'b1, 4'h0);

    // Non-data command table: qpi_mode must only change after deselect.
    exp_prev = 1'b0;
    for (int i = 0; i < 14; i++) begin
      send_cmd(tbl[i].cmd);
      model_cmd(tbl[i].cmd);
      check("cmd_busy", busy, 1);
      check("cmd_qpi_hold", qpi_mode, exp_prev);
      step(1'b0, 4'($urandom));
      check("cmd_ignore_busy", busy, 1);
      check("cmd_ignore_oe", data_oe, 4'h0);
      step(1'b1, 4'h0);
      model_deselect();
      check("cmd_qpi_after", qpi_mode, tbl[i].exp_qpi);
      check("cmd_busy_after", busy, 0);
      check("cmd_oe_after", data_oe, 4'h0);
      exp_prev = tbl[i].exp_qpi;
    end

    // QPI write A5 3C at 0x10, read back nibble stream.
    wdat[0] = 8'hA5; wdat[1] = 8'h3C;
    do_write(24'h000010, 2, 1'b0);
    do_read(24'h000010, 2);
    check("rd_a5", rb[0], 8'hA5);
    check("rd_3c", rb[1], 8'h3C);

    // Address wrap at the top of a 1 KiB memory.
    wdat[0] = 8'h11; wdat[1] = 8'h22;
    do_write(24'h0003FF, 2, 1'b0);
    do_read(24'h000000, 1);
    check("wrap_0", rb[0], 8'h22);
    do_read(24'h0003FF, 2);
    check("wrap_3ff", rb[0], 8'h11);
    check("wrap_next", rb[1], 8'h22);

    // Deselect after a lone high nibble leaves the next byte untouched.
    wdat[0] = 8'h5E;
    do_write(24'h000021, 1, 1'b0);
    wdat[0] = 8'h77;
    do_write(24'h000020, 1, 1'b1);
    do_read(24'h000020, 2);
    check("partial_20", rb[0], 8'h77);
    check("partial_21", rb[1], 8'h5E);

    // rst asserted in the middle of a QPI read.
    send_cmd(8'hEB);
    send_addr(24'h000010);
    for (int i = 0; i < W; i++) step(1'b0, 4'h0);
    check("pre_rst_oe", data_oe, 4'hF);
    step(1'b0, 4'h0);
    rst = 1'b1;
    step(1'b0, 4'h0);
    check("rst_oe", data_oe, 4'h0);
    check("rst_data_out", data_out, 4'h0);
    check("rst_busy", busy, 0);
    check("rst_qpi", qpi_mode, 0);
    rst = 1'b0;
    step(1'b1, 4'h0);
    qpi_m = 1'b0; armed_m = 1'b0; pend_m = 1'b0;
    do_read(24'h000010, 2);
    check("spi_rd_a5", rb[0], 8'hA5);
    check("spi_rd_3c", rb[1], 8'h3C);

    // SPI-mode write with upper address bits set.
    wdat[0] = 8'hC3; wdat[1] = 8'h96;
    do_write(24'hFFF130, 2, 1'b0);
    do_read(24'h000130, 2);
    check("spi_wr_0", rb[0], 8'hC3);
    check("spi_wr_1", rb[1], 8'h96);

    // Randomized traffic against the model.
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      if (r < 4) begin
        n = $urandom_range(1, 4);
        for (int b = 0; b < n; b++) wdat[b] = 8'($urandom);
        do_write(24'($urandom), n, 1'($urandom));
      end else if (r < 8) begin
        n = $urandom_range(1, 3);
        a = {14'($urandom), written_q[$urandom_range(0, written_q.size() - 1)][9:0]};
        do_read(a, n);
      end else begin
        mode_cmd(qpi_m ? 8'hF5 : 8'h35);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
